// File: rtl/memory_stage.sv
// Memory stage of an in-order RISC-V pipeline: decodes LOAD/STORE, drives a
// req/gnt/rvalid data-memory port, and returns extended load data.

module memory_stage_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] data,
  output logic        be,
  output logic [7:0]  wbyte
);
  localparam logic [1:0] LIDX = 2'(LANE);

  // Each lane picks its byte of the replicated store pattern.
  always_comb begin
    be    = 1'b0;
    wbyte = data[7:0];
    case (size)
      2'b00: be = (off == LIDX);
      2'b01: begin
        be    = (off[1] == LIDX[1]);
        wbyte = data[8*(LANE%2) +: 8];
      end
      2'b10: begin
        be    = 1'b1;
        wbyte = data[8*LANE +: 8];
      end
      default: ;
    endcase
  end
endmodule

module memory_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] valE_i,
  input  logic [31:0] val2_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] valM_o,
  output logic        misalign_o,
  output logic        err_o
);
  localparam int NUM_LANES = 4;
  localparam int CW        = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t state_q, state_d;

  logic [31:2]                addr_q;
  logic [1:0]                 off_q;
  logic [NUM_LANES-1:0]       be_q;
  logic [31:0]                wdata_q;
  logic                       we_q;
  logic [2:0]                 f3_q;
  logic [CW-1:0]              cnt_q;
  logic [31:0]                valM_q;
  logic                       misalign_q, err_q;

  logic [NUM_LANES-1:0]       be_d;
  logic [NUM_LANES-1:0][7:0]  wdata_d;

  // decode of the incoming instruction
  logic is_load, is_store, is_mem, f3_ok, mis, go_mem;
  assign is_load  = (opcode_i == OP_LOAD);
  assign is_store = (opcode_i == OP_STORE);
  assign is_mem   = is_load | is_store;
  always_comb begin
    f3_ok = 1'b0;
    if (is_load)
      f3_ok = (funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    else if (is_store)
      f3_ok = (funct3_i inside {3'b000, 3'b001, 3'b010});
  end
  assign mis    = (funct3_i[1:0] == 2'b01 && valE_i[0]) ||
                  (funct3_i[1:0] == 2'b10 && valE_i[1:0] != 2'b00);
  assign go_mem = is_mem & f3_ok & ~mis;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    memory_stage_lane #(.LANE(l)) u_lane (
      .size  (funct3_i[1:0]),
      .off   (valE_i[1:0]),
      .data  (val2_i),
      .be    (be_d[l]),
      .wbyte (wdata_d[l])
    );
  end

  // load extraction: align addressed byte/half to bit 0, then extend
  logic [31:0] shifted, load_ext;
  assign shifted = dmem_rdata_i >> {off_q, 3'b000};
  always_comb begin
    load_ext = dmem_rdata_i;
    case (f3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'd0, shifted[7:0]};
      3'b101:  load_ext = {16'd0, shifted[15:0]};
      default: load_ext = dmem_rdata_i;
    endcase
  end

  // Timeout fires on the TIMEOUT_CYCLES-th outstanding cycle unless the bus
  // makes progress in that same cycle.
  logic tmo_hit;
  assign tmo_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_i) state_d = go_mem ? REQ : DONE;
      REQ: begin
        if (dmem_gnt_i)   state_d = we_q ? DONE : WAIT;
        else if (tmo_hit) state_d = DONE;
      end
      WAIT: begin
        if (dmem_rvalid_i) state_d = DONE;
        else if (tmo_hit)  state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      off_q      <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      f3_q       <= '0;
      cnt_q      <= '0;
      valM_q     <= '0;
      misalign_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (start_i) begin
          valM_q     <= '0;
          err_q      <= is_mem & ~f3_ok;
          misalign_q <= is_mem & f3_ok & mis;
          if (go_mem) begin
            addr_q  <= valE_i[31:2];
            off_q   <= valE_i[1:0];
            be_q    <= be_d;
            wdata_q <= wdata_d;
            we_q    <= is_store;
            f3_q    <= funct3_i;
            cnt_q   <= '0;
          end
        end
        REQ: begin
          cnt_q <= cnt_q + CW'(1);
          if (!dmem_gnt_i && tmo_hit) err_q <= 1'b1;
        end
        WAIT: begin
          cnt_q <= cnt_q + CW'(1);
          if (dmem_rvalid_i)  valM_q <= load_ext;
          else if (tmo_hit)   err_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  logic req;
  assign req          = (state_q == REQ);
  assign dmem_req_o   = req;
  assign dmem_we_o    = req & we_q;
  assign dmem_addr_o  = req ? {addr_q, 2'b00} : '0;
  assign dmem_be_o    = req ? be_q : '0;
  assign dmem_wdata_o = req ? wdata_q : '0;
  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE);
  assign valM_o       = done_o ? valM_q : '0;
  assign misalign_o   = done_o & misalign_q;
  assign err_o        = done_o & err_q;
endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: aligned/misaligned loads and stores,
// illegal funct3, non-memory ops, timeout and mid-access reset.

module tb_memory_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] valE, val2;
  logic        req, we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt, rvalid;
  logic [31:0] rdata;
  logic        busy, done;
  logic [31:0] valM;
  logic        misalign, err;

  int pass_cnt = 0;
  int total_cnt = 0;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] ALU   = 7'b0110011;

  memory_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .opcode_i(opcode),
    .funct3_i(funct3), .valE_i(valE), .val2_i(val2),
    .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(addr), .dmem_be_o(be),
    .dmem_wdata_o(wdata), .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid),
    .dmem_rdata_i(rdata), .busy_o(busy), .done_o(done), .valM_o(valM),
    .misalign_o(misalign), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] e, input logic [31:0] d);
    start = 1'b1; opcode = op; funct3 = f3; valE = e; val2 = d;
    tick;
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 0; opcode = 0; funct3 = 0; valE = 0; val2 = 0;
    gnt = 0; rvalid = 0; rdata = 0;
    #12;
    total_cnt++;
    if ({req, we, addr, be, wdata, busy, done, valM, misalign, err} !== '0)
      $display("FAIL reset_outputs: got req=%b busy=%b done=%b addr=%h valM=%h, want all 0",
               req, busy, done, addr, valM);
    else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    tick;
  endtask

  task automatic test_lw;
    issue(LOAD, 3'b010, 32'h100, 0);
    total_cnt++;
    if ({req, we, addr, be, busy} !== {1'b1, 1'b0, 32'h100, 4'b1111, 1'b1})
      $display("FAIL lw_req: got req=%b we=%b addr=%h be=%b busy=%b, want 1 0 00000100 1111 1",
               req, we, addr, be, busy);
    else pass_cnt++;
    gnt = 1; tick; gnt = 0;
    total_cnt++;
    if ({req, done} !== 2'b00) $display("FAIL lw_wait: got req=%b done=%b, want 0 0", req, done);
    else pass_cnt++;
    rvalid = 1; rdata = 32'hDEADBEEF; tick; rvalid = 0;
    total_cnt++;
    if ({done, valM, err, misalign} !== {1'b1, 32'hDEADBEEF, 2'b00})
      $display("FAIL lw_done: got done=%b valM=%h err=%b mis=%b, want 1 deadbeef 0 0",
               done, valM, err, misalign);
    else pass_cnt++;
    tick;
    total_cnt++;
    if ({done, busy} !== 2'b00) $display("FAIL lw_idle: got done=%b busy=%b, want 0 0", done, busy);
    else pass_cnt++;
  endtask

  task automatic test_lb_lbu;
    logic [2:0]  f3s [2] = '{3'b000, 3'b100};
    logic [31:0] exp [2] = '{32'hFFFFFF80, 32'h00000080};
    for (int i = 0; i < 2; i++) begin
      issue(LOAD, f3s[i], 32'h103, 0);
      total_cnt++;
      if ({addr, be} !== {32'h100, 4'b1000})
        $display("FAIL lb_be[%0d]: got addr=%h be=%b, want 00000100 1000", i, addr, be);
      else pass_cnt++;
      gnt = 1; tick; gnt = 0;
      rvalid = 1; rdata = 32'h80112233; tick; rvalid = 0;
      total_cnt++;
      if ({done, valM} !== {1'b1, exp[i]})
        $display("FAIL lb_valM[%0d]: got done=%b valM=%h, want 1 %h", i, done, valM, exp[i]);
      else pass_cnt++;
      tick;
    end
  endtask

  task automatic test_lh_signed;
    issue(LOAD, 3'b001, 32'h202, 0);
    gnt = 1; tick; gnt = 0;
    rvalid = 1; rdata = 32'h9ABC1234; tick; rvalid = 0;
    total_cnt++;
    if ({done, valM} !== {1'b1, 32'hFFFF9ABC})
      $display("FAIL lh_valM: got done=%b valM=%h, want 1 ffff9abc", done, valM);
    else pass_cnt++;
    tick;
  endtask

  task automatic test_sh;
    issue(STORE, 3'b001, 32'h102, 32'h0000ABCD);
    total_cnt++;
    if ({req, we, addr, be, wdata} !== {2'b11, 32'h100, 4'b1100, 32'hABCDABCD})
      $display("FAIL sh_bus: got req=%b we=%b addr=%h be=%b wdata=%h, want 1 1 00000100 1100 abcdabcd",
               req, we, addr, be, wdata);
    else pass_cnt++;
    gnt = 1; tick; gnt = 0;
    total_cnt++;
    if ({done, req, valM, err} !== {2'b10, 32'h0, 1'b0})
      $display("FAIL sh_done: got done=%b req=%b valM=%h err=%b, want 1 0 0 0", done, req, valM, err);
    else pass_cnt++;
    tick;
  endtask

  task automatic test_sb_hold;
    // request must stay stable while the grant is withheld
    issue(STORE, 3'b000, 32'h301, 32'h123456A5);
    tick; tick;
    total_cnt++;
    if ({req, we, addr, be, wdata} !== {2'b11, 32'h300, 4'b0010, 32'hA5A5A5A5})
      $display("FAIL sb_hold: got req=%b we=%b addr=%h be=%b wdata=%h, want 1 1 00000300 0010 a5a5a5a5",
               req, we, addr, be, wdata);
    else pass_cnt++;
    gnt = 1; tick; gnt = 0;
    total_cnt++;
    if ({done, err} !== 2'b10) $display("FAIL sb_done: got done=%b err=%b, want 1 0", done, err);
    else pass_cnt++;
    tick;
  endtask

  task automatic test_faults;
    logic [6:0]  ops [4] = '{LOAD, LOAD, STORE, ALU};
    logic [2:0]  f3s [4] = '{3'b010, 3'b011, 3'b100, 3'b010};
    logic [31:0] ads [4] = '{32'h101, 32'h100, 32'h100, 32'h101};
    logic [1:0]  flg [4] = '{2'b10, 2'b01, 2'b01, 2'b00}; // {misalign, err}
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], f3s[i], ads[i], 32'hFFFFFFFF);
      total_cnt++;
      if ({done, req, misalign, err, valM} !== {2'b10, flg[i], 32'h0})
        $display("FAIL fault[%0d]: got done=%b req=%b mis=%b err=%b valM=%h, want 1 0 %b 0",
                 i, done, req, misalign, err, valM, flg[i]);
      else pass_cnt++;
      tick;
    end
  endtask

  task automatic test_timeout;
    issue(LOAD, 3'b010, 32'h400, 0);
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if ({req, done} !== 2'b10)
        $display("FAIL tmo_req[%0d]: got req=%b done=%b, want 1 0", i, req, done);
      else pass_cnt++;
      tick;
    end
    total_cnt++;
    if ({done, err, req, valM} !== {2'b11, 1'b0, 32'h0})
      $display("FAIL tmo_done: got done=%b err=%b req=%b valM=%h, want 1 1 0 0", done, err, req, valM);
    else pass_cnt++;
    tick;
  endtask

  task automatic test_back_to_back;
    issue(LOAD, 3'b010, 32'h500, 0);
    // start and a stray rvalid while busy in REQ must both be ignored
    start = 1; opcode = ALU; rvalid = 1; rdata = 32'hBAD0BAD0;
    tick;
    start = 0; rvalid = 0;
    total_cnt++;
    if ({req, done} !== 2'b10) $display("FAIL b2b_ignore: got req=%b done=%b, want 1 0", req, done);
    else pass_cnt++;
    gnt = 1; tick; gnt = 0;
    rvalid = 1; rdata = 32'h12345678; tick; rvalid = 0;
    total_cnt++;
    if ({done, valM} !== {1'b1, 32'h12345678})
      $display("FAIL b2b_valM: got done=%b valM=%h, want 1 12345678", done, valM);
    else pass_cnt++;
    start = 1; opcode = ALU;
    tick;
    start = 0;
    total_cnt++;
    if ({done, busy} !== 2'b00)
      $display("FAIL b2b_done_start: got done=%b busy=%b, want 0 0", done, busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    issue(LOAD, 3'b010, 32'h600, 0);
    gnt = 1; tick; gnt = 0;
    #2 rst_n = 1'b0; #1;
    total_cnt++;
    if ({req, busy, done, valM, err} !== '0)
      $display("FAIL rst_mid: got req=%b busy=%b done=%b valM=%h err=%b, want 0", req, busy, done, valM, err);
    else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    tick;
    rvalid = 1; rdata = 32'hCAFEF00D; tick; rvalid = 0;
    total_cnt++;
    if ({done, busy, valM} !== '0)
      $display("FAIL rst_rvalid: got done=%b busy=%b valM=%h, want 0 0 0", done, busy, valM);
    else pass_cnt++;
    tick;
    total_cnt++;
    if ({done, busy} !== '0) $display("FAIL rst_idle: got done=%b busy=%b, want 0 0", done, busy);
    else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_lw;
    test_lb_lbu;
    test_lh_signed;
    test_sh;
    test_sb_hold;
    test_faults;
    test_timeout;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the maximum cycles a bus access may stay outstanding before it is aborted.
REQ-002 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n_i  input  1  SHALL be the reset, asynchronous and active-low.
REQ-004 start_i  input  1  SHALL be a one-cycle pulse marking a valid instruction from the execute stage.
REQ-005 opcode_i  input  7  SHALL carry the instruction opcode.
REQ-006 funct3_i  input  3  SHALL carry the access size and sign field.
REQ-007 valE_i  input  32  SHALL carry the effective address from the execute stage.
REQ-008 val2_i  input  32  SHALL carry the store data (rs2).
REQ-009 dmem_req_o  output  1  SHALL request a data-memory transfer.
REQ-010 dmem_we_o  output  1  SHALL be 1 for a store, 0 for a load.
REQ-011 dmem_addr_o  output  32  SHALL be the word-aligned address, valE_i with bits [1:0] cleared.
REQ-012 dmem_be_o  output  4  SHALL be the byte enables.
REQ-013 dmem_wdata_o  output  32  SHALL be store data replicated into the addressed lanes.
REQ-014 dmem_gnt_i  input  1  SHALL indicate the memory accepted the request this cycle.
REQ-015 dmem_rvalid_i  input  1  SHALL qualify dmem_rdata_i.
REQ-016 dmem_rdata_i  input  32  SHALL carry the read word.
REQ-017 busy_o  output  1  SHALL be high in every state except IDLE; upstream stalls on it.
REQ-018 done_o  output  1  SHALL pulse for exactly one cycle when an instruction completes.
REQ-019 valM_o  output  32  SHALL carry the extended load result, valid while done_o=1.
REQ-020 misalign_o, err_o  output  1 each  SHALL flag misaligned access and illegal-funct3/timeout respectively, valid while done_o=1.

Function
REQ-021 The FSM SHALL have states IDLE, REQ, WAIT, DONE.
REQ-022 In IDLE, start_i is accepted; start_i while busy_o=1 SHALL be ignored.
REQ-023 For an opcode other than LOAD (0000011) or STORE (0100011), the FSM SHALL go IDLE->DONE, with valM_o=0, no flags, and no bus activity.
REQ-024 Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW. Any other value SHALL go IDLE->DONE with err_o=1 and no bus activity.
REQ-025 A halfword with valE_i[0]=1 or a word with valE_i[1:0]!=0 SHALL go IDLE->DONE with misalign_o=1 and no bus activity.
REQ-026 A legal aligned access SHALL go IDLE->REQ, registering address, be, wdata and type on the accept edge.
REQ-027 dmem_req_o SHALL be high exactly in REQ, with addr/we/be/wdata held stable until dmem_gnt_i.
REQ-028 In REQ with dmem_gnt_i=1: a store SHALL go to DONE and a load SHALL go to WAIT.
REQ-029 In WAIT with dmem_rvalid_i=1, the FSM SHALL capture rdata and go to DONE; rvalid outside WAIT SHALL be ignored.
REQ-030 Byte enables SHALL be: byte 0001<<addr[1:0], half 0011<<addr[1:0], word 1111. Store data: byte {4{val2_i[7:0]}}, half {2{val2_i[15:0]}}, word val2_i.
REQ-031 Load extraction SHALL shift rdata right by 8*addr[1:0], then sign-extend (LB/LH) or zero-extend (LBU/LHU).
REQ-032 A cycle counter SHALL clear on entry to REQ, increment in REQ and WAIT, and on reaching TIMEOUT_CYCLES go to DONE with err_o=1, valM_o=0, dmem_req_o dropped.
REQ-033 DONE SHALL last one cycle with done_o=1, then return to IDLE; a start_i in the DONE cycle SHALL be ignored.
REQ-034 Minimum latency start_i->done_o: 1 cycle for non-memory/faulting instructions, 2 for a store with immediate gnt, 3 for a load with gnt and rvalid on consecutive cycles.

Reset
REQ-035 While rst_n_i=0, the FSM SHALL be IDLE and all outputs 0 (dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o, busy_o, done_o, valM_o, misalign_o, err_o) and the counter 0.
REQ-036 Reset asserted mid-access SHALL drop dmem_req_o asynchronously; a later rvalid SHALL be ignored.

Verification
REQ-037 LW at valE=0x100, gnt the next cycle, rvalid=1 with rdata=0xDEADBEEF one cycle later -> done_o 3 cycles after start_i, valM_o=0xDEADBEEF.
REQ-038 LB at 0x103, rdata=0x80112233 -> valM_o=0xFFFFFF80; LBU gives 0x00000080.
REQ-039 SH at 0x102, val2=0x0000ABCD -> be=1100, wdata=0xABCDABCD, addr=0x100, done_o 2 cycles after start_i.
REQ-040 LW at 0x101 -> done_o next cycle, misalign_o=1, dmem_req_o never asserted.
REQ-041 With TIMEOUT_CYCLES=4, LW with gnt held at 0 -> req drops, done_o with err_o=1 after 4 counted cycles.
REQ-042 rst_n_i low during WAIT, then rvalid pulse after release -> outputs 0, no done_o, FSM IDLE.
